seq_div08: RTL and testbench

SEQ_DIV08 -- requirements
Module: seq_div08

---
 rtl/seq_div08.sv | 122 ++++++++++++
 tb/tb_seq_div08.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_div08.sv
// Iterative restoring unsigned 8/8 divider.
// Produces one quotient bit per cycle, MSB first.
module seq_div08 (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] quotient,
  output logic [7:0] remainder,
  output logic       div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nx;

  logic [2:0] cnt;
  logic [7:0] dvd;
  logic [7:0] dvs;
  logic [7:0] prem;
  logic [7:0] quo;

  logic [8:0] t;
  logic [9:0] d;
  logic       borrow;
  logic       qbit;
  logic [7:0] prem_nx;
  logic [7:0] quo_nx;
  logic       accept;
  logic       last;
  logic       zero_dvs;

  assign t = {prem, dvd[3'd7 - cnt]};
  assign d = {1'b0, t} + {2'b11, ~dvs} + 10'd1;

  // d[9:8] is 2'b00 when t >= divisor and 2'b11 otherwise
  assign borrow  = |d[9:8];
  assign qbit    = ~borrow;
  assign prem_nx = borrow ? t[7:0] : d[7:0];
  assign quo_nx  = {quo[6:0], qbit};

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign last      = (cnt == 3'd7);
  assign zero_dvs  = (divisor == 8'd0);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nx = zero_dvs ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (last) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= 3'd0;
      dvd         <= 8'd0;
      dvs         <= 8'd0;
      prem        <= 8'd0;
      quo         <= 8'd0;
      quotient    <= 8'd0;
      remainder   <= 8'd0;
      div_by_zero <= 1'b0;
    end else begin
      if (accept) begin
        dvd  <= dividend;
        dvs  <= divisor;
        prem <= 8'd0;
        quo  <= 8'd0;
        cnt  <= 3'd0;
        if (zero_dvs) begin
          quotient    <= 8'hFF;
          remainder   <= dividend;
          div_by_zero <= 1'b1;
        end
      end else if (state == BUSY) begin
        prem <= prem_nx;
        quo  <= quo_nx;
        cnt  <= cnt + 3'd1;
        if (last) begin
          quotient    <= quo_nx;
          remainder   <= prem_nx;
          div_by_zero <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_div08.sv
// Directed and random checks for seq_div08.
// Vector table, handshake corner cases, reset abort, random model.
module tb_seq_div08;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int errors = 0;
  int checks = 0;

  seq_div08 dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready;
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      step();
      n++;
    end
    chk("in_ready_timeout", int'(in_ready), 1);
  endtask

  // waits for out_valid and returns the number of edges after accept
  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk("out_valid_timeout", int'(out_valid), 1);
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] eq, input logic [7:0] er,
                       input logic ez, input bit rnd);
    int  n;
    bit  hs;
    wait_ready();
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_done(n);
    chk("latency", n, (b == 8'd0) ? 0 : 8);
    chk("quotient", int'(quotient), int'(eq));
    chk("remainder", int'(remainder), int'(er));
    chk("div_by_zero", int'(div_by_zero), int'(ez));
    if (b != 8'd0) begin
      chk("invariant", int'(quotient) * int'(b) + int'(remainder), int'(a));
      chk("rem_lt_div", int'(remainder < b), 1);
    end
    hs = 1'b0;
    for (int i = 0; i < 64 && !hs; i++) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      hs = out_ready;
      step();
      if (!hs) chk("hold_valid", int'(out_valid), 1);
    end
    out_ready = 1'b0;
    if (!hs) begin
      chk("handshake_timeout", 0, 1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    chk("idle_after_hs", int'(in_ready), 1);
  endtask

  initial begin
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] eq;
    logic [7:0] er;
    int         n;

    vecs[0] = '{8'd200, 8'd7,   8'd28,  8'd4,   1'b0};
    vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
    vecs[2] = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0};
    vecs[3] = '{8'd0,   8'd3,   8'd0,   8'd0,   1'b0};
    vecs[4] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0};
    vecs[5] = '{8'd100, 8'd0,   8'hFF,  8'd100, 1'b1};
    vecs[6] = '{8'd100, 8'd3,   8'd33,  8'd1,   1'b0};
    vecs[7] = '{8'd128, 8'd16,  8'd8,   8'd0,   1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = 8'd0;
    divisor   = 8'd0;

    step();
    step();
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_quotient", int'(quotient), 0);
    chk("rst_remainder", int'(remainder), 0);
    chk("rst_dbz", int'(div_by_zero), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", int'(in_ready), 1);

    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z, 1'b0);
    end

    // held result, ignored in_valid in BUSY and DONE
    wait_ready();
    dividend = 8'd200;
    divisor  = 8'd7;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dividend = 8'd9;
      divisor  = 8'd9;
      in_valid = (i != 1);
      step();
    end
    in_valid = 1'b0;
    wait_done(n);
    chk("hold_latency", n, 5);
    for (int i = 0; i < 5; i++) begin
      dividend = 8'd50;
      divisor  = 8'd0;
      in_valid = (i % 2 == 0);
      chk("hold_q", int'(quotient), 28);
      chk("hold_r", int'(remainder), 4);
      chk("hold_z", int'(div_by_zero), 0);
      step();
      chk("hold_ov", int'(out_valid), 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("hs_ov_low", int'(out_valid), 0);
    chk("hs_idle", int'(in_ready), 1);
    chk("idle_keep_q", int'(quotient), 28);
    step();
    chk("no_capture", int'(out_valid), 0);

    // reset during the 4th BUSY cycle
    dividend = 8'd200;
    divisor  = 8'd7;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    #1;
    chk("abort_in_ready_rst", int'(in_ready), 0);
    step();
    rst = 1'b0;
    #1;
    chk("abort_ov", int'(out_valid), 0);
    chk("abort_q", int'(quotient), 0);
    chk("abort_r", int'(remainder), 0);
    chk("abort_z", int'(div_by_zero), 0);
    chk("abort_idle", int'(in_ready), 1);
    do_op(8'd17, 8'd4, 8'd4, 8'd1, 1'b0, 1'b0);

    // random back-to-back operands with random out_ready
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom_range(0, 255));
      b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      if (b == 8'd0) begin
        eq = 8'hFF;
        er = a;
      end else begin
        eq = a / b;
        er = a % b;
      end
      do_op(a, b, eq, er, (b == 8'd0), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
